// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the nibble-serial adder sequencer.
//   - seqStateT : controller state encoding (IDLE / RUN / DONE)
//   - NIBBLE_W  : width of one slice handled by the shared adder
//   - cntWidth(): width of the nibble counter for a given slice count
// Optional feature macro used by the sequencer: ADDSUB_EN.
// ---------------------------------------------------------------------------
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } seqStateT;

    // Counter must reach nibbles-1; never narrower than one bit.
    function automatic int cntWidth(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/adder_cl.sv
// ---------------------------------------------------------------------------
// adder_cl
// 4-bit carry-lookahead adder, purely combinational.
// Ports:
//   a, b : 4-bit addends
//   ci   : carry in
//   s    : 4-bit sum
//   co   : carry out of bit 3
// ---------------------------------------------------------------------------
module adder_cl (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] gen;
    logic [3:0] prop;
    logic [4:0] carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Every carry is formed directly from generate/propagate terms so no
    // carry ripples through a previous stage.
    assign carry[0] = ci;
    assign carry[1] = gen[0] | (prop[0] & ci);
    assign carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & ci);
    assign carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                    | (prop[2] & prop[1] & prop[0] & ci);
    assign carry[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                    | (prop[3] & prop[2] & prop[1] & gen[0])
                    | (prop[3] & prop[2] & prop[1] & prop[0] & ci);

    assign s  = prop ^ carry[3:0];
    assign co = carry[4];

endmodule

// File: rtl/adder_seq_ctrl.sv
// ---------------------------------------------------------------------------
// adder_seq_ctrl
// Adds two W-bit operands (W = 4*NIBBLES) one nibble per cycle on a single
// shared 4-bit carry-lookahead adder. Operands are captured on an accepted
// start; the nibble sums are shifted into an accumulator from the MSB end and
// the finished sum is registered on completion.
//
// Optional feature: define ADDSUB_EN to add a 'sub' input (a - b via a + ~b + 1,
// co = no-borrow) and an 'ovf' output (signed overflow of the W-bit result).
//
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset, aborts any operation
//   start   : request, honoured only in IDLE or DONE
//   a, b    : W-bit operands, captured on accepted start
//   ci      : carry in, captured on accepted start
//   sub     : (ADDSUB_EN) subtract instead of add
//   s, co   : registered sum and final carry, updated only on completion
//   busy    : high while operation in progress
//   done    : one-cycle completion pulse
//   ovf     : (ADDSUB_EN) signed overflow, registered with s
// ---------------------------------------------------------------------------
module adder_seq_ctrl
    import adder_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIBBLES * NIBBLE_W
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
`ifdef ADDSUB_EN
    input  logic         sub,
`endif
    output logic [W-1:0] s,
    output logic         co,
    output logic         busy,
`ifdef ADDSUB_EN
    output logic         ovf,
`endif
    output logic         done
);

    localparam int             CW   = cntWidth(NIBBLES);
    localparam logic [CW-1:0]  LAST = CW'(NIBBLES - 1);

    seqStateT        state;
    logic [W-1:0]    opa;
    logic [W-1:0]    opb;
    logic [W-1:0]    acc;
    logic            cr;
    logic [CW-1:0]   cnt;

    logic [NIBBLE_W-1:0] nibSum;
    logic                nibCo;
    logic [W-1:0]        accNext;
    logic [W-1:0]        opbLoad;
    logic                crLoad;

    adder_cl uAdder (
        .a  (opa[NIBBLE_W-1:0]),
        .b  (opb[NIBBLE_W-1:0]),
        .ci (cr),
        .s  (nibSum),
        .co (nibCo)
    );

    // The newest nibble enters at the top; after NIBBLES shifts the first
    // nibble has reached bit 0 and the accumulator holds the whole sum.
    assign accNext = {nibSum, acc[W-1:NIBBLE_W]};

`ifdef ADDSUB_EN
    // Subtraction is a + ~b + 1, reusing the same adder path.
    assign opbLoad = sub ? ~b   : b;
    assign crLoad  = sub ? 1'b1 : ci;

    // On the last nibble opa/opb bit 3 are the operand sign bits and
    // nibSum bit 3 is the result sign bit.
    logic ovfLast;
    assign ovfLast = (opa[NIBBLE_W-1] == opb[NIBBLE_W-1])
                  && (nibSum[NIBBLE_W-1] != opa[NIBBLE_W-1]);
`else
    assign opbLoad = b;
    assign crLoad  = ci;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
            cr    <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            co    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef ADDSUB_EN
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= opbLoad;
                        cr    <= crLoad;
                        cnt   <= '0;
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    acc <= accNext;
                    cr  <= nibCo;
                    opa <= {{NIBBLE_W{1'b0}}, opa[W-1:NIBBLE_W]};
                    opb <= {{NIBBLE_W{1'b0}}, opb[W-1:NIBBLE_W]};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        s     <= accNext;
                        co    <= nibCo;
`ifdef ADDSUB_EN
                        ovf   <= ovfLast;
`endif
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
Multi-cycle sequencer that adds two wide operands one nibble per cycle on a single shared 4-bit carry-lookahead adder (adder_cl).
- Captures operands on a start/done handshake.
- Holds the carry between nibbles and assembles the wide sum.
- Serves as the area-lean alternative to a wide parallel adder in the arithmetic datapath.

Parameters:
NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES (minimum 2)

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE or DONE
a  input  W  operand A, captured on accepted start
b  input  W  operand B, captured on accepted start
ci  input  1  carry-in, captured on accepted start
s  output  W  registered sum; valid from done until next completion
co  output  1  registered final carry-out
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse on completion

Behaviour:
- Reset (reset_n low, any time, including mid-operation): aborts the operation immediately and asynchronously.
  - State goes to IDLE.
  - s=0, co=0, busy=0, done=0.
  - Operand registers, carry register and counter are cleared.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at an edge captures a, b, ci into internal registers opa, opb, cr; counter cnt=0; state becomes RUN.
- RUN, each cycle:
  - adder_cl computes opa[3:0] + opb[3:0] + cr combinationally.
  - At the edge, the nibble sum shifts into acc at the MSB end (acc shifts right by 4).
  - cr takes the adder co; opa and opb shift right by 4; cnt increments.
  - When cnt = NIBBLES-1 at an edge, state becomes DONE. At that same edge s takes the final acc value including the last nibble, and co takes the last adder co.
- DONE lasts exactly one cycle, with done=1 and busy=0.
  - start=1 in DONE is accepted as back-to-back: capture occurs and state goes to RUN.
  - Otherwise state goes to IDLE.
- Latency: start accepted at edge k; done is high during the cycle following edge k+NIBBLES.
- start while in RUN is ignored; operands and inputs are not re-sampled.
- s and co change only at completion. They hold their value through IDLE and through subsequent RUN cycles until the next completion.
- Arithmetic is unsigned modulo 2^W. co is the carry out of bit W-1. The inter-nibble carry is exactly the adder_cl co; there is no extra carry logic.

Optional Feature:
Macro ADDSUB_EN.
- Defined:
  - Adds input port sub (1 bit) and output port ovf (1 bit, reset 0).
  - On an accepted start with sub=1: captures ~b as opb and forces cr=1, ignoring ci. co then means no-borrow (1 means a>=b).
  - ovf is two's-complement signed overflow of the full W-bit result, registered with s.
- Undefined: neither port exists; the block performs pure addition as above.

Decomposition:
- Shared package adder_pkg holds:
  - state encodings ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10
  - NIBBLE_W=4
  - counter width as a clog2-based function of NIBBLES
- Sub-module: exactly one instance of the existing adder_cl (4-bit a, b, ci -> s, co). The controller owns everything else: FSM, counter, shift registers and the carry flop.

Test Plan (NIBBLES=4):
- Reset: assert reset_n=0 two cycles after accepting start -> busy=0, done=0, s=16'h0000, co=0 immediately. After release, no done pulse occurs.
- a=16'h1234, b=16'h4321, ci=0, start at edge k -> done high only in the cycle after edge k+4; s=16'h5555, co=0; busy high for exactly 4 cycles.
- a=16'hFFFF, b=16'h0001, ci=0 -> s=16'h0000, co=1 (carry propagates through all 4 nibbles). Then a=16'hFFFF, b=16'hFFFF, ci=1 -> s=16'hFFFF, co=1.
- Start held high continuously with a=16'h0F0F, b=16'h0101: a second start during RUN is ignored. Start in the DONE cycle begins a new operation; done pulses every 5 cycles with s=16'h1010.
- Exhaustive: NIBBLES=2, all a, b in 0..255 with ci in {0,1} -> {co,s} equals a+b+ci for every case.
- With ADDSUB_EN defined: sub=1, a=16'h0005, b=16'h0007 -> s=16'hFFFE, co=0, ovf=0. Then sub=1, a=16'h8000, b=16'h0001 -> s=16'h7FFF, co=1, ovf=1.
